clksw_sched: RTL and testbench
==============================

Name: clksw_sched

Overview:
- Sequences the CPU clock switcher: decides when the CPU runs on the high-speed divided clock and when it runs on the system low-speed clock.
- Drives the switcher's hsclk_sel and cpuclk_div_sel, and waits for the switcher's hsclk_selected/lsclk_selected handshake before releasing the CPU.
- Sits between the address-decode/config-register logic and the clock switcher.
- Runs entirely on lsclk_in, which is always running.

Parameters:
- TIMEOUT_CYC, 15, lsclk cycles allowed for a switch acknowledge before error.
- HOLD_CYC, 4, minimum lsclk cycles spent in LS_RUN before returning to high speed (hysteresis).
- CNT_W, 4, width of the shared cycle counter; must hold max(TIMEOUT_CYC, HOLD_CYC).

Ports:
- lsclk_in  in  1  sole clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- ls_req  in  1  current access needs low-speed clock (registered decode, lsclk domain).
- cfg_wr  in  1  single-cycle config write strobe.
- cfg_wdata  in  3  [0]=hs_en, [2:1]=div_sel.
- hsclk_selected  in  1  switcher status, HS clock driving CPU.
- lsclk_selected  in  1  switcher status, LS clock driving CPU.
- hsclk_sel  out  1  request to switcher (1 = high speed).
- cpuclk_div_sel  out  2  active divider select to switcher.
- cpu_rdy  out  1  CPU ready; low stalls the CPU during switching.
- switching  out  1  high in TO_HS or TO_LS.
- timeout_err  out  1  sticky acknowledge-timeout flag; cleared by any cfg_wr.

Behaviour:
- Reset values: state LS_RUN, hsclk_sel 0, cpuclk_div_sel 2'b00, pending cfg {hs_en=0, div=00}, counter 0, timeout_err 0, switching 0, cpu_rdy 1.
- cfg_wr captures cfg_wdata into the pending register on the same edge.
- Pending div is copied to cpuclk_div_sel only in LS_RUN. The divider never changes while HS may be driving the CPU. The copy takes one cycle after the write, or on the first LS_RUN cycle after a pending write.
- go_hs = hs_en & !ls_req & (counter >= HOLD_CYC) & !timeout_err.
- States:
  - LS_RUN:
    - hsclk_sel=0; counter increments, saturating.
    - If go_hs: move to TO_HS, clear counter, assert hsclk_sel on the same edge.
  - TO_HS:
    - hsclk_sel=1; counter increments.
    - If ls_req or !hs_en: abort to TO_LS, hsclk_sel=0, counter cleared.
    - Else if sampled hsclk_selected & !lsclk_selected: move to HS_RUN.
    - Else if counter==TIMEOUT_CYC: set timeout_err, move to TO_LS.
  - HS_RUN:
    - hsclk_sel=1.
    - If ls_req or !hs_en: move to TO_LS, hsclk_sel=0, counter cleared.
  - TO_LS:
    - hsclk_sel=0; counter increments.
    - If sampled lsclk_selected & !hsclk_selected: move to LS_RUN, counter cleared (starts hold).
    - If counter==TIMEOUT_CYC: set timeout_err, remain in TO_LS. A safer state does not exist. The counter saturates.
- cpu_rdy = (state==LS_RUN) | (state==HS_RUN & !ls_req). This is combinational, so a slow access is never completed at high speed.
- switching = state is TO_HS or TO_LS (registered state decode).
- timeout_err blocks go_hs until cleared by cfg_wr. A cfg_wr in the same cycle as a timeout leaves the flag set: set wins.
- Simultaneous ls_req and cfg_wr: the state transition uses the pre-write hs_en; the new value applies from the next cycle.
- Asynchronous reset mid-switch returns to LS_RUN with hsclk_sel=0 immediately. This matches the switcher's own reset to LS.
- Counter arithmetic: unsigned CNT_W bits, saturating at all-ones, never wraps.

Decomposition:
- Shared package clksw_pkg holds:
  - state enum LS_RUN=0, TO_HS=1, HS_RUN=2, TO_LS=3;
  - cfg bit positions CFG_HS_EN=0, CFG_DIV_LSB=1;
  - divider codes DIV1=00, DIV2=01, DIV4=10, DIV8=11.
- One sub-module, clksw_cnt: saturating up-counter with synchronous clear plus compare outputs ge_hold and eq_timeout. It is shared by the hold and timeout functions because the two are never active at the same time.

Test Plan:
- Reset, then cfg_wr hs_en=1 div=10 with ls_req=0 → cpuclk_div_sel=10 after 1 cycle. TO_HS entered once the counter reaches 4. hsclk_selected asserted 3 cycles later → HS_RUN; cpu_rdy low only during TO_HS.
- In HS_RUN, raise ls_req → cpu_rdy low in the same cycle, hsclk_sel=0 next edge. lsclk_selected after 4 cycles → LS_RUN. No return to HS for 4 cycles even with ls_req dropped.
- In TO_HS, raise ls_req before the acknowledge → immediate abort to TO_LS, no HS_RUN visit, timeout_err stays 0.
- Never assert hsclk_selected → timeout_err=1 at counter 15, state TO_LS then LS_RUN. A later cfg_wr clears the flag and the next switch proceeds.
- cfg_wr div=11 while in HS_RUN → cpuclk_div_sel unchanged until the first LS_RUN cycle, then 11.
- Assert rst_b=0 in the middle of TO_HS → hsclk_sel=0, state LS_RUN, timeout_err=0, cpu_rdy=1 without waiting for a clock edge.

Source files
------------

// File: rtl/clksw_pkg.sv
// Shared definitions for the CPU clock-switch scheduler: FSM states,
// config-word bit positions and divider codes.
`timescale 1ns/1ps
package clksw_pkg;

   // Scheduler states; the encoding is visible on the debug port.
   typedef enum logic [1:0] {
      LS_RUN = 2'd0,
      TO_HS  = 2'd1,
      HS_RUN = 2'd2,
      TO_LS  = 2'd3
   } state_t;

   // Config write word layout: [0] = hs_en, [2:1] = divider select.
   localparam int CFG_W       = 3;
   localparam int CFG_HS_EN   = 0;
   localparam int CFG_DIV_LSB = 1;

   // Divider codes understood by the clock switcher.
   localparam logic [1:0] DIV1 = 2'b00;
   localparam logic [1:0] DIV2 = 2'b01;
   localparam logic [1:0] DIV4 = 2'b10;
   localparam logic [1:0] DIV8 = 2'b11;

   // True while a switch is in flight and the CPU clock source is uncertain.
   function automatic logic is_switching(input state_t s);
      return (s == TO_HS) || (s == TO_LS);
   endfunction

endpackage

// File: rtl/clksw_cnt.sv
// Saturating cycle counter shared by the LS_RUN hold time and the
// switch-acknowledge timeout; the two are never measured at once.
`timescale 1ns/1ps
module clksw_cnt #(
   parameter int CNT_W       = 4,
   parameter int HOLD_CYC    = 4,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic i_clk,
   input  logic i_rst_b,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_ge_hold,
   output logic o_eq_timeout
);

   localparam logic [CNT_W-1:0] L_MAX     = '1;
   localparam logic [CNT_W-1:0] L_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] L_HOLD    = CNT_W'(HOLD_CYC);
   localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT_CYC);

   logic [CNT_W-1:0] r_cnt;

   // Clear has priority; incrementing stops at all-ones so the count never wraps.
   always_ff @(posedge i_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != L_MAX)) begin
         r_cnt <= r_cnt + L_ONE;
      end
   end

   assign o_ge_hold    = (r_cnt >= L_HOLD);
   assign o_eq_timeout = (r_cnt == L_TIMEOUT);

endmodule

// File: rtl/clksw_sched.sv
// CPU clock-switch scheduler. Runs on the always-on low-speed clock,
// requests high/low speed from the clock switcher, waits for its
// acknowledge and stalls the CPU while the source is changing.
//
// Handshake: hsclk_sel is a level request; the switch is complete only
// when the switcher reports exactly the requested source (selected for
// the target high, selected for the other side low). cpu_rdy low means
// the CPU must not complete the current access.
`timescale 1ns/1ps
module clksw_sched
   import clksw_pkg::*;
#(
   parameter int TIMEOUT_CYC = 15,
   parameter int HOLD_CYC    = 4,
   parameter int CNT_W       = 4
) (
   input  logic             lsclk_in,
   input  logic             rst_b,
   input  logic             ls_req,
   input  logic             cfg_wr,
   input  logic [CFG_W-1:0] cfg_wdata,
   input  logic             hsclk_selected,
   input  logic             lsclk_selected,
   output logic             hsclk_sel,
   output logic [1:0]       cpuclk_div_sel,
   output logic             cpu_rdy,
   output logic             switching,
   output logic             timeout_err,
   output state_t           o_dbg_state
);

   state_t     r_state;
   logic       r_hsclk_sel;
   logic       r_switching;
   logic       r_pend_hs_en;
   logic [1:0] r_pend_div;
   logic [1:0] r_div_sel;
   logic       r_timeout_err;

   logic w_ge_hold;
   logic w_eq_timeout;
   logic w_go_hs;
   logic w_abort;
   logic w_hs_ack;
   logic w_ls_ack;
   logic w_cnt_clr;
   logic w_cnt_inc;
   logic w_to_set;

   // Decisions use the pending config as it stood before this edge, so a
   // write in the same cycle only takes effect from the next cycle.
   assign w_go_hs  = r_pend_hs_en & ~ls_req & w_ge_hold & ~r_timeout_err;
   assign w_abort  = ls_req | ~r_pend_hs_en;
   assign w_hs_ack = hsclk_selected & ~lsclk_selected;
   assign w_ls_ack = lsclk_selected & ~hsclk_selected;

   clksw_cnt #(
      .CNT_W       (CNT_W),
      .HOLD_CYC    (HOLD_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_cnt (
      .i_clk        (lsclk_in),
      .i_rst_b      (rst_b),
      .i_clr        (w_cnt_clr),
      .i_inc        (w_cnt_inc),
      .o_ge_hold    (w_ge_hold),
      .o_eq_timeout (w_eq_timeout)
   );

   // Counter control and timeout detection for the current state.
   always_comb begin
      w_cnt_clr = 1'b0;
      w_cnt_inc = 1'b0;
      w_to_set  = 1'b0;
      case (r_state)
         LS_RUN: begin
            w_cnt_inc = 1'b1;
            w_cnt_clr = w_go_hs;
         end
         TO_HS: begin
            w_cnt_inc = 1'b1;
            if (w_abort) begin
               w_cnt_clr = 1'b1;
            end else if (!w_hs_ack && w_eq_timeout) begin
               // Fresh window for the return trip to low speed.
               w_cnt_clr = 1'b1;
               w_to_set  = 1'b1;
            end
         end
         HS_RUN: begin
            w_cnt_clr = w_abort;
         end
         TO_LS: begin
            w_cnt_inc = 1'b1;
            if (w_ls_ack) begin
               // Arrival in LS_RUN starts the hold time from zero.
               w_cnt_clr = 1'b1;
            end else if (w_eq_timeout) begin
               w_to_set = 1'b1;
            end
         end
         default: begin
            w_cnt_clr = 1'b1;
         end
      endcase
   end

   // Switch sequencing FSM with registered request and switching flag.
   always_ff @(posedge lsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         r_state     <= LS_RUN;
         r_hsclk_sel <= 1'b0;
         r_switching <= 1'b0;
      end else begin
         case (r_state)
            LS_RUN: begin
               if (w_go_hs) begin
                  r_state     <= TO_HS;
                  r_hsclk_sel <= 1'b1;
                  r_switching <= 1'b1;
               end
            end
            TO_HS: begin
               if (w_abort) begin
                  r_state     <= TO_LS;
                  r_hsclk_sel <= 1'b0;
                  r_switching <= 1'b1;
               end else if (w_hs_ack) begin
                  r_state     <= HS_RUN;
                  r_hsclk_sel <= 1'b1;
                  r_switching <= 1'b0;
               end else if (w_eq_timeout) begin
                  r_state     <= TO_LS;
                  r_hsclk_sel <= 1'b0;
                  r_switching <= 1'b1;
               end
            end
            HS_RUN: begin
               if (w_abort) begin
                  r_state     <= TO_LS;
                  r_hsclk_sel <= 1'b0;
                  r_switching <= 1'b1;
               end
            end
            TO_LS: begin
               // No safer place exists than TO_LS; stay until the switcher
               // confirms low speed.
               if (w_ls_ack) begin
                  r_state     <= LS_RUN;
                  r_hsclk_sel <= 1'b0;
                  r_switching <= 1'b0;
               end
            end
            default: begin
               r_state     <= LS_RUN;
               r_hsclk_sel <= 1'b0;
               r_switching <= 1'b0;
            end
         endcase
      end
   end

   // Pending config capture and divider hand-over, only while LS clocks the CPU.
   always_ff @(posedge lsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         r_pend_hs_en <= 1'b0;
         r_pend_div   <= DIV1;
         r_div_sel    <= DIV1;
      end else begin
         if (cfg_wr) begin
            r_pend_hs_en <= cfg_wdata[CFG_HS_EN];
            r_pend_div   <= cfg_wdata[CFG_DIV_LSB +: 2];
         end
         if (r_state == LS_RUN) begin
            r_div_sel <= r_pend_div;
         end
      end
   end

   // Sticky timeout flag; a timeout in the same cycle as a config write wins.
   always_ff @(posedge lsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         r_timeout_err <= 1'b0;
      end else if (w_to_set) begin
         r_timeout_err <= 1'b1;
      end else if (cfg_wr) begin
         r_timeout_err <= 1'b0;
      end
   end

   // cpu_rdy reacts to ls_req combinationally so a slow access never
   // completes on the high-speed clock.
   assign cpu_rdy        = (r_state == LS_RUN) | ((r_state == HS_RUN) & ~ls_req);
   assign hsclk_sel      = r_hsclk_sel;
   assign cpuclk_div_sel = r_div_sel;
   assign switching      = r_switching;
   assign timeout_err    = r_timeout_err;
   assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_clksw_sched.sv
// Self-checking bench for clksw_sched: directed scenarios plus a
// randomized run against a cycle-level behavioural model and a small
// clock-switcher emulator with configurable acknowledge latency.
`timescale 1ns/1ps
module tb_clksw_sched;
   import clksw_pkg::*;

   localparam int TIMEOUT_CYC = 15;
   localparam int HOLD_CYC    = 4;
   localparam int CNT_W       = 4;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   localparam int M_LS   = 0;
   localparam int M_TOHS = 1;
   localparam int M_HS   = 2;
   localparam int M_TOLS = 3;

   logic       lsclk_in = 1'b0;
   logic       rst_b = 1'b0;
   logic       ls_req = 1'b0;
   logic       cfg_wr = 1'b0;
   logic [2:0] cfg_wdata = 3'b000;
   logic       hsclk_selected = 1'b0;
   logic       lsclk_selected = 1'b1;
   logic       hsclk_sel;
   logic [1:0] cpuclk_div_sel;
   logic       cpu_rdy;
   logic       switching;
   logic       timeout_err;
   state_t     dbg_state;

   int n_cmp = 0;
   int n_fail = 0;
   logic [6:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 lsclk_in = ~lsclk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
      $fatal(1, "watchdog");
   end

   clksw_sched #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .HOLD_CYC    (HOLD_CYC),
      .CNT_W       (CNT_W)
   ) dut (
      .lsclk_in       (lsclk_in),
      .rst_b          (rst_b),
      .ls_req         (ls_req),
      .cfg_wr         (cfg_wr),
      .cfg_wdata      (cfg_wdata),
      .hsclk_selected (hsclk_selected),
      .lsclk_selected (lsclk_selected),
      .hsclk_sel      (hsclk_sel),
      .cpuclk_div_sel (cpuclk_div_sel),
      .cpu_rdy        (cpu_rdy),
      .switching      (switching),
      .timeout_err    (timeout_err),
      .o_dbg_state    (dbg_state)
   );

   // ---------------- reference model ----------------
   int         m_mode;
   int         m_cnt;
   bit         m_hs_en;
   bit         m_err;
   bit         m_hsel;
   logic [1:0] m_pend_div;
   logic [1:0] m_div;

   function automatic void model_reset();
      m_mode = M_LS; m_cnt = 0; m_hs_en = 0; m_err = 0; m_hsel = 0;
      m_pend_div = 2'b00; m_div = 2'b00;
   endfunction

   function automatic int sat_inc(input int v);
      return (v >= CNT_MAX) ? CNT_MAX : v + 1;
   endfunction

   // One rising edge of lsclk, from the scheduling rules.
   function automatic void model_clock();
      bit go, leave_hs, hs_ok, ls_ok, err_now;
      int nxt, ncnt;
      go       = m_hs_en && !ls_req && (m_cnt >= HOLD_CYC) && !m_err;
      leave_hs = ls_req || !m_hs_en;
      hs_ok    = hsclk_selected && !lsclk_selected;
      ls_ok    = lsclk_selected && !hsclk_selected;
      nxt = m_mode; ncnt = m_cnt; err_now = 0;
      case (m_mode)
         M_LS: begin
            ncnt = sat_inc(m_cnt);
            if (go) begin nxt = M_TOHS; ncnt = 0; end
         end
         M_TOHS: begin
            ncnt = sat_inc(m_cnt);
            if (leave_hs) begin nxt = M_TOLS; ncnt = 0; end
            else if (hs_ok) nxt = M_HS;
            else if (m_cnt == TIMEOUT_CYC) begin nxt = M_TOLS; ncnt = 0; err_now = 1; end
         end
         M_HS: begin
            if (leave_hs) begin nxt = M_TOLS; ncnt = 0; end
         end
         default: begin
            ncnt = sat_inc(m_cnt);
            if (ls_ok) begin nxt = M_LS; ncnt = 0; end
            else if (m_cnt == TIMEOUT_CYC) err_now = 1;
         end
      endcase
      if (m_mode == M_LS) m_div = m_pend_div;
      if (err_now) m_err = 1;
      else if (cfg_wr) m_err = 0;
      if (cfg_wr) begin
         m_hs_en    = cfg_wdata[0];
         m_pend_div = cfg_wdata[2:1];
      end
      m_mode = nxt;
      m_cnt  = ncnt;
      m_hsel = (nxt == M_TOHS) || (nxt == M_HS);
   endfunction

   function automatic logic [6:0] model_vec();
      logic [1:0] s;
      s = m_mode[1:0];
      return {s, m_hsel, m_div, (m_mode == M_TOHS) || (m_mode == M_TOLS), m_err};
   endfunction

   function automatic bit model_rdy();
      return (m_mode == M_LS) || ((m_mode == M_HS) && !ls_req);
   endfunction

   // ---------------- clock switcher emulator ----------------
   bit sw_hs = 0;
   bit sw_ls = 1;
   int emu_wait = 0;
   int emu_lat = 2;
   bit emu_dead = 0;
   bit emu_rand = 0;

   function automatic void emu_reset();
      sw_hs = 0; sw_ls = 1; emu_wait = 0; emu_dead = 0;
      hsclk_selected = 0; lsclk_selected = 1;
   endfunction

   // Break-before-make: both selects drop while moving, target appears after emu_lat.
   function automatic void emu_update();
      if ((m_hsel != sw_hs) || (m_hsel == sw_ls)) begin
         sw_hs = 0; sw_ls = 0;
         emu_wait++;
         if (!emu_dead && emu_wait >= emu_lat) begin
            sw_hs = m_hsel; sw_ls = !m_hsel; emu_wait = 0;
            if (emu_rand) emu_lat = $urandom_range(1, 6);
         end
      end else begin
         emu_wait = 0;
      end
      hsclk_selected = sw_hs;
      lsclk_selected = sw_ls;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge lsclk_in);
      model_clock();
      #1;
      emu_update();
   endtask

   task automatic run_until(input state_t target, input int budget, output bit hit, output int n);
      hit = 0; n = 0;
      while (!hit && n < budget) begin
         tick();
         n++;
         if (dbg_state == target) hit = 1;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      model_reset(); emu_reset();
      rst_b = 0;
      repeat (2) @(posedge lsclk_in);
      #1;
      n_cmp++; if (dbg_state !== LS_RUN) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
      n_cmp++; if (hsclk_sel !== 1'b0) begin n_fail++; $display("FAIL rst_hsel: got %b expected 0", hsclk_sel); end
      n_cmp++; if (cpuclk_div_sel !== 2'b00) begin n_fail++; $display("FAIL rst_div: got %b expected 00", cpuclk_div_sel); end
      n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", timeout_err); end
      n_cmp++; if (switching !== 1'b0) begin n_fail++; $display("FAIL rst_switching: got %b expected 0", switching); end
      n_cmp++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_rdy: got %b expected 1", cpu_rdy); end
      rst_b = 1;
   endtask

   task automatic test_hs_entry();
      bit hit;
      int n_tohs;
      logic [6:0] act;
      emu_lat = 3;
      ls_req = 0;
      cfg_wr = 1; cfg_wdata = {DIV4, 1'b1};
      tick();
      cfg_wr = 0;
      tick();
      n_cmp++; if (cpuclk_div_sel !== DIV4) begin n_fail++; $display("FAIL entry_div: got %b expected 10", cpuclk_div_sel); end
      hit = 0; n_tohs = 0;
      for (int k = 0; k < 30 && !hit; k++) begin
         #1;
         n_cmp++; if (cpu_rdy !== (m_mode != M_TOHS)) begin n_fail++; $display("FAIL entry_rdy: got %b expected %b", cpu_rdy, m_mode != M_TOHS); end
         tick();
         act = {dbg_state, hsclk_sel, cpuclk_div_sel, switching, timeout_err};
         n_cmp++; if (act !== model_vec()) begin n_fail++; $display("FAIL entry_vec: got %h expected %h", act, model_vec()); end
         if (dbg_state == TO_HS) n_tohs++;
         if (dbg_state == HS_RUN) hit = 1;
      end
      n_cmp++; if (hit !== 1'b1) begin n_fail++; $display("FAIL entry_reach_hs: got %b expected 1", hit); end
      n_cmp++; if (n_tohs !== 3) begin n_fail++; $display("FAIL entry_tohs_len: got %0d expected 3", n_tohs); end
   endtask

   task automatic test_hs_exit();
      bit hit;
      int n, n_ls;
      emu_lat = 4;
      ls_req = 1;
      #1;
      n_cmp++; if (cpu_rdy !== 1'b0) begin n_fail++; $display("FAIL exit_rdy_comb: got %b expected 0", cpu_rdy); end
      tick();
      n_cmp++; if (hsclk_sel !== 1'b0) begin n_fail++; $display("FAIL exit_hsel: got %b expected 0", hsclk_sel); end
      n_cmp++; if (dbg_state !== TO_LS) begin n_fail++; $display("FAIL exit_state: got %0d expected 3", dbg_state); end
      run_until(LS_RUN, 20, hit, n);
      n_cmp++; if (hit !== 1'b1) begin n_fail++; $display("FAIL exit_reach_ls: got %b expected 1", hit); end
      n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL exit_ack_wait: got %0d expected 4", n); end
      ls_req = 0;
      n_ls = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (dbg_state != LS_RUN) break;
         n_ls++;
      end
      n_cmp++; if (n_ls !== HOLD_CYC) begin n_fail++; $display("FAIL exit_hold: got %0d expected %0d", n_ls, HOLD_CYC); end
      n_cmp++; if (dbg_state !== TO_HS) begin n_fail++; $display("FAIL exit_rehs: got %0d expected 1", dbg_state); end
   endtask

   task automatic test_abort();
      bit hit, seen_hs, reached;
      int n;
      emu_lat = 2;
      ls_req = 1;
      run_until(LS_RUN, 30, hit, n);
      emu_lat = 10;
      ls_req = 0;
      run_until(TO_HS, 20, hit, n);
      n_cmp++; if (hit !== 1'b1) begin n_fail++; $display("FAIL abort_reach_tohs: got %b expected 1", hit); end
      tick(); tick();
      ls_req = 1;
      tick();
      n_cmp++; if (dbg_state !== TO_LS) begin n_fail++; $display("FAIL abort_state: got %0d expected 3", dbg_state); end
      n_cmp++; if (hsclk_sel !== 1'b0) begin n_fail++; $display("FAIL abort_hsel: got %b expected 0", hsclk_sel); end
      seen_hs = 0; reached = 0;
      for (int k = 0; k < 20 && !reached; k++) begin
         tick();
         if (dbg_state == HS_RUN) seen_hs = 1;
         if (dbg_state == LS_RUN) reached = 1;
      end
      n_cmp++; if (seen_hs !== 1'b0) begin n_fail++; $display("FAIL abort_no_hs: got %b expected 0", seen_hs); end
      n_cmp++; if (reached !== 1'b1) begin n_fail++; $display("FAIL abort_reach_ls: got %b expected 1", reached); end
      n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b expected 0", timeout_err); end
   endtask

   task automatic test_timeout();
      bit hit;
      int n;
      emu_lat = 2;
      emu_dead = 1;
      ls_req = 0;
      run_until(TO_HS, 20, hit, n);
      n_cmp++; if (hit !== 1'b1) begin n_fail++; $display("FAIL to_reach_tohs: got %b expected 1", hit); end
      n = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         n++;
         if (dbg_state != TO_HS) break;
      end
      n_cmp++; if (n !== TIMEOUT_CYC + 1) begin n_fail++; $display("FAIL to_len: got %0d expected %0d", n, TIMEOUT_CYC + 1); end
      n_cmp++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err_set: got %b expected 1", timeout_err); end
      n_cmp++; if (dbg_state !== TO_LS) begin n_fail++; $display("FAIL to_state: got %0d expected 3", dbg_state); end
      repeat (20) tick();
      cfg_wr = 1; cfg_wdata = {DIV4, 1'b1};
      tick();
      cfg_wr = 0;
      n_cmp++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_set_wins: got %b expected 1", timeout_err); end
      emu_dead = 0;
      run_until(LS_RUN, 10, hit, n);
      n_cmp++; if (hit !== 1'b1) begin n_fail++; $display("FAIL to_reach_ls: got %b expected 1", hit); end
      repeat (8) tick();
      n_cmp++; if (dbg_state !== LS_RUN) begin n_fail++; $display("FAIL to_blocked: got %0d expected 0", dbg_state); end
      cfg_wr = 1; cfg_wdata = {DIV4, 1'b1};
      tick();
      cfg_wr = 0;
      n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_err_clear: got %b expected 0", timeout_err); end
      run_until(HS_RUN, 20, hit, n);
      n_cmp++; if (hit !== 1'b1) begin n_fail++; $display("FAIL to_recover_hs: got %b expected 1", hit); end
   endtask

   task automatic test_div_in_hs();
      bit hit;
      int n;
      cfg_wr = 1; cfg_wdata = {DIV8, 1'b1};
      tick();
      cfg_wr = 0;
      repeat (3) tick();
      n_cmp++; if (cpuclk_div_sel !== DIV4) begin n_fail++; $display("FAIL div_hold_hs: got %b expected 10", cpuclk_div_sel); end
      emu_lat = 2;
      ls_req = 1;
      run_until(LS_RUN, 20, hit, n);
      n_cmp++; if (hit !== 1'b1) begin n_fail++; $display("FAIL div_reach_ls: got %b expected 1", hit); end
      n_cmp++; if (cpuclk_div_sel !== DIV4) begin n_fail++; $display("FAIL div_first_ls: got %b expected 10", cpuclk_div_sel); end
      tick();
      n_cmp++; if (cpuclk_div_sel !== DIV8) begin n_fail++; $display("FAIL div_copied: got %b expected 11", cpuclk_div_sel); end
   endtask

   task automatic test_same_cycle();
      bit hit;
      int n;
      emu_lat = 2;
      repeat (6) tick();
      ls_req = 0;
      cfg_wr = 1; cfg_wdata = {DIV8, 1'b0};
      tick();
      cfg_wr = 0;
      n_cmp++; if (dbg_state !== TO_HS) begin n_fail++; $display("FAIL same_old_hs_en: got %0d expected 1", dbg_state); end
      tick();
      n_cmp++; if (dbg_state !== TO_LS) begin n_fail++; $display("FAIL same_new_hs_en: got %0d expected 3", dbg_state); end
      run_until(LS_RUN, 20, hit, n);
      repeat (10) tick();
      n_cmp++; if (dbg_state !== LS_RUN) begin n_fail++; $display("FAIL same_stay_ls: got %0d expected 0", dbg_state); end
   endtask

   task automatic test_reset_mid();
      bit hit;
      int n;
      emu_dead = 1;
      cfg_wr = 1; cfg_wdata = {DIV2, 1'b1};
      tick();
      cfg_wr = 0;
      run_until(TO_HS, 20, hit, n);
      tick(); tick(); tick();
      n_cmp++; if (hsclk_sel !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_hsel: got %b expected 1", hsclk_sel); end
      #2;
      rst_b = 0;
      #1;
      n_cmp++; if (hsclk_sel !== 1'b0) begin n_fail++; $display("FAIL rmid_hsel: got %b expected 0", hsclk_sel); end
      n_cmp++; if (dbg_state !== LS_RUN) begin n_fail++; $display("FAIL rmid_state: got %0d expected 0", dbg_state); end
      n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rmid_err: got %b expected 0", timeout_err); end
      n_cmp++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL rmid_rdy: got %b expected 1", cpu_rdy); end
      model_reset(); emu_reset();
      @(negedge lsclk_in);
      rst_b = 1;
   endtask

   task automatic test_random();
      logic [6:0] act, exp_v;
      emu_rand = 1;
      for (int i = 0; i < 900; i++) begin
         if ($urandom_range(0, 5) == 0) ls_req = ~ls_req;
         cfg_wr = ($urandom_range(0, 24) == 0);
         cfg_wdata = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 4) != 0)};
         if (emu_dead) begin
            if ($urandom_range(0, 9) == 0) emu_dead = 0;
         end else if ($urandom_range(0, 59) == 0) begin
            emu_dead = 1;
         end
         #1;
         n_cmp++; if (cpu_rdy !== model_rdy()) begin n_fail++; $display("FAIL rand_rdy cyc %0d: got %b expected %b", i, cpu_rdy, model_rdy()); end
         tick();
         exp_q.push_back(model_vec());
         exp_v = exp_q.pop_front();
         act = {dbg_state, hsclk_sel, cpuclk_div_sel, switching, timeout_err};
         n_cmp++; if (act !== exp_v) begin n_fail++; $display("FAIL rand_vec cyc %0d: got %h expected %h", i, act, exp_v); end
      end
      cfg_wr = 0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_hs_entry();
      test_hs_exit();
      test_abort();
      test_timeout();
      test_div_in_hs();
      test_same_cycle();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
